// File: rtl/vga_fb_fetch_pkg.sv
// Shared types and helpers for the VGA framebuffer pixel fetcher.
package vga_fb_fetch_pkg;

  localparam int unsigned PIX_W  = 24;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone
  } fetch_state_e;

  // Memory words are 0x00RRGGBB; the top byte is padding.
  function automatic logic [PIX_W-1:0] word_to_rgb(input logic [WORD_W-1:0] word);
    return word[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/vga_fb_fetch_if.sv
// Framebuffer read port: valid/ready request channel plus in-order response channel.
interface vga_fb_fetch_if
  import vga_fb_fetch_pkg::*;
;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [WORD_W-1:0] rd_req_addr;
  logic              rd_rsp_valid;
  logic [WORD_W-1:0] rd_rsp_data;

  modport master (
    output rd_req_valid,
    output rd_req_addr,
    input  rd_req_ready,
    input  rd_rsp_valid,
    input  rd_rsp_data
  );

  modport slave (
    input  rd_req_valid,
    input  rd_req_addr,
    output rd_req_ready,
    output rd_rsp_valid,
    output rd_rsp_data
  );
endinterface

// File: rtl/vga_fb_fifo.sv
// Show-ahead pixel FIFO with synchronous flush; head_o is the oldest entry (undefined when empty).
module vga_fb_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         head_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Flush has priority over both push and pop.
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/vga_fb_fetch.sv
// Framebuffer pixel fetcher: streams one frame of pixel words into a show-ahead FIFO for the VGA
// controller. Define VGA_FB_FETCH_STATS_EN to add the per-frame underflow_cnt output.
module vga_fb_fetch
  import vga_fb_fetch_pkg::*;
#(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] fb_base,
  input  logic              frame_start,
  input  logic              pix_pop,
  vga_fb_fetch_if.master    rd,
  output logic [PIX_W-1:0]  vga_data,
  output logic              underflow
`ifdef VGA_FB_FETCH_STATS_EN
  ,
  output logic [15:0]       underflow_cnt
`endif
);
  localparam int unsigned NPIX  = H_RES * V_RES;
  localparam int unsigned IDX_W = $clog2(NPIX);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              underflow_q, underflow_d;

  logic [PIX_W-1:0]  fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, fifo_full;
  logic              req_fire, rsp_take, fifo_push, uf_event;
  logic [CNT_W:0]    credit_used;

  // Credits cover both queued pixels and in-flight reads, so the FIFO can never overflow.
  assign credit_used     = {1'b0, fifo_count} + {1'b0, outst_q};
  assign rd.rd_req_valid = (state_q == StFill) && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign rd.rd_req_addr  = base_q + WORD_W'({idx_q, 2'b00});

  assign req_fire  = rd.rd_req_valid & rd.rd_req_ready;
  // Responses with nothing in flight are leftovers from before a reset.
  assign rsp_take  = rd.rd_rsp_valid & (outst_q != '0);
  assign fifo_push = rsp_take & (drop_q == '0);
  assign uf_event  = pix_pop & fifo_empty & ~frame_start;

  assign vga_data  = fifo_empty ? '0 : fifo_head;
  assign underflow = underflow_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    idx_d       = idx_q;
    drop_d      = drop_q;
    underflow_d = underflow_q;
    outst_d     = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_take);

    if (rsp_take && drop_q != '0) drop_d = drop_q - CNT_W'(1);
    if (req_fire) begin
      idx_d = idx_q + IDX_W'(1);
      if (idx_q == LAST_IDX) state_d = StDone;
    end
    if (uf_event) underflow_d = 1'b1;

    if (frame_start) begin
      state_d     = StFill;
      base_d      = fb_base;
      idx_d       = '0;
      drop_d      = outst_d;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      idx_q       <= '0;
      outst_q     <= '0;
      drop_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      underflow_q <= underflow_d;
    end
  end

  vga_fb_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (PIX_W)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .flush_i     (frame_start),
    .push_i      (fifo_push),
    .push_data_i (word_to_rgb(rd.rd_rsp_data)),
    .pop_i       (pix_pop & ~frame_start),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

`ifdef VGA_FB_FETCH_STATS_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;

  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if (frame_start) uf_cnt_d = '0;
    else if (uf_event && uf_cnt_q != 16'hFFFF) uf_cnt_d = uf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) uf_cnt_q <= '0;
    else          uf_cnt_q <= uf_cnt_d;
  end

  assign underflow_cnt = uf_cnt_q;
`endif

  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;

endmodule
